// File: rtl/microgreen_vote_filter_if.sv
`default_nettype none
// ============================================================================
// microgreen_vote_filter_if : sample stream in, filtered decision/counters out
// Revision 1.0
// ============================================================================
interface microgreen_vote_filter_if #(
  parameter int WIN   = 8,
  parameter int CNT_W = 16
);
  localparam int OW = $clog2(WIN + 1);

  logic             clear;
  logic             in_valid;
  logic [2:0]       in_class;
  logic             decision;
  logic             decision_valid;
  logic             decision_changed;
  logic [OW-1:0]    ones_count;
  logic [CNT_W-1:0] sample_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output clear, in_valid, in_class,
    input  decision, decision_valid, decision_changed,
    input  ones_count, sample_count, err_count
  );

  modport slave (
    input  clear, in_valid, in_class,
    output decision, decision_valid, decision_changed,
    output ones_count, sample_count, err_count
  );
endinterface
`default_nettype wire

// File: rtl/microgreen_vote_filter.sv
`default_nettype none
// ============================================================================
// microgreen_vote_filter : sliding-window majority vote with hysteresis
// Revision 1.0
// ============================================================================
module microgreen_vote_filter #(
  parameter int WIN    = 8,
  parameter int THRESH = 6,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  microgreen_vote_filter_if.slave  bus
);

  localparam int OW     = $clog2(WIN + 1);
  localparam int FW     = $clog2(WIN);
  localparam int WIN_M1 = WIN - 1;

  localparam logic [OW:0]      C_WIN       = WIN[OW:0];
  localparam logic [OW:0]      C_THRESH    = THRESH[OW:0];
  localparam logic [FW-1:0]    C_FILL_LAST = WIN_M1[FW-1:0];
  localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;

  generate
    if (WIN < 2 || WIN > 16 || THRESH <= WIN / 2 || THRESH > WIN) begin : g_param_check
      $error("microgreen_vote_filter: illegal WIN/THRESH combination");
    end
  endgenerate

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIN-1:0]   r_window;
  logic [OW-1:0]    r_ones;
  logic [FW-1:0]    r_fill;
  logic             r_decision;
  logic             r_valid;
  logic             r_changed;
  logic [CNT_W-1:0] r_samples;
  logic [CNT_W-1:0] r_errors;

  logic             w_legal;
  logic             w_illegal;
  logic             w_vote;
  logic             w_oldest;
  logic [OW:0]      w_ones_new;
  logic             w_majority;
  logic             w_set;
  logic             w_release;

  assign w_legal    = bus.in_valid && (bus.in_class[2:1] == 2'b00);
  assign w_illegal  = bus.in_valid && (bus.in_class[2:1] != 2'b00);
  assign w_vote     = bus.in_class[0];
  assign w_oldest   = (r_state == TRACK) ? r_window[WIN-1] : 1'b0;
  // One extra bit so the add and subtract can share a cycle without overflow.
  assign w_ones_new = {1'b0, r_ones} + {{OW{1'b0}}, w_vote} - {{OW{1'b0}}, w_oldest};
  assign w_majority = {w_ones_new[OW-1:0], 1'b0} > C_WIN;
  assign w_set      = w_ones_new >= C_THRESH;
  assign w_release  = (C_WIN - w_ones_new) >= C_THRESH;

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      r_state    <= FILL;
      r_window   <= '0;
      r_ones     <= '0;
      r_fill     <= '0;
      r_decision <= 1'b0;
      r_valid    <= 1'b0;
      r_changed  <= 1'b0;
      r_samples  <= '0;
      r_errors   <= '0;
    end else begin
      r_changed <= 1'b0;
      if (w_illegal && r_errors != C_CNT_MAX) begin
        r_errors <= r_errors + 1'b1;
      end
      if (w_legal) begin
        r_window <= {r_window[WIN-2:0], w_vote};
        r_ones   <= w_ones_new[OW-1:0];
        if (r_samples != C_CNT_MAX) begin
          r_samples <= r_samples + 1'b1;
        end
        case (r_state)
          FILL: begin
            r_fill <= r_fill + 1'b1;
            if (r_fill == C_FILL_LAST) begin
              r_state    <= TRACK;
              r_valid    <= 1'b1;
              r_decision <= w_majority;
            end
          end
          TRACK: begin
            if (!r_decision && w_set) begin
              r_decision <= 1'b1;
              r_changed  <= 1'b1;
            end else if (r_decision && w_release) begin
              r_decision <= 1'b0;
              r_changed  <= 1'b1;
            end
          end
          default: r_state <= FILL;
        endcase
      end
    end
  end

  assign bus.decision         = r_decision;
  assign bus.decision_valid   = r_valid;
  assign bus.decision_changed = r_changed;
  assign bus.ones_count       = r_ones;
  assign bus.sample_count     = r_samples;
  assign bus.err_count        = r_errors;

endmodule
`default_nettype wire

// File: tb/tb_microgreen_vote_filter.sv
`default_nettype none
// ============================================================================
// tb_microgreen_vote_filter : directed steps checked against a reference model
// Revision 1.0
// ============================================================================
module tb_microgreen_vote_filter;

  localparam int WIN    = 8;
  localparam int THRESH = 6;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  microgreen_vote_filter_if #(.WIN(WIN), .CNT_W(CNT_W)) bus ();

  microgreen_vote_filter #(.WIN(WIN), .THRESH(THRESH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       dec;
    logic       val;
    logic       chg;
    logic [3:0] ones;
    logic [3:0] samp;
    logic [3:0] err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [WIN-1:0] m_win;
  int             m_fill, m_samp, m_err;
  logic           m_track, m_dec, m_val, m_chg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic c, input logic v, input logic [2:0] cls);
    int ones;
    if (r || c) begin
      m_win = '0; m_fill = 0; m_track = 0; m_dec = 0;
      m_val = 0;  m_chg = 0;  m_samp = 0;  m_err = 0;
    end else begin
      m_chg = 0;
      if (v) begin
        if (cls > 3'd1) begin
          if (m_err < 15) m_err++;
        end else begin
          m_win = {m_win[WIN-2:0], cls[0]};
          if (m_samp < 15) m_samp++;
          ones = $countones(m_win);
          if (!m_track) begin
            m_fill++;
            if (m_fill == WIN) begin
              m_track = 1; m_val = 1; m_dec = (2 * ones > WIN);
            end
          end else if (!m_dec && ones >= THRESH) begin
            m_dec = 1; m_chg = 1;
          end else if (m_dec && (WIN - ones) >= THRESH) begin
            m_dec = 0; m_chg = 1;
          end
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic c, input logic v, input logic [2:0] cls);
    exp_t e;
    @(negedge clk);
    rst = r; bus.clear = c; bus.in_valid = v; bus.in_class = cls;
    model_update(r, c, v, cls);
    e.dec = m_dec; e.val = m_val; e.chg = m_chg;
    e.ones = 4'($countones(m_win)); e.samp = 4'(m_samp); e.err = 4'(m_err);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("decision",         32'(bus.decision),         32'(e.dec));
    check("decision_valid",   32'(bus.decision_valid),   32'(e.val));
    check("decision_changed", 32'(bus.decision_changed), 32'(e.chg));
    check("ones_count",       32'(bus.ones_count),       32'(e.ones));
    check("sample_count",     32'(bus.sample_count),     32'(e.samp));
    check("err_count",        32'(bus.err_count),        32'(e.err));
  endtask

  task automatic sample(input logic [2:0] cls);
    step(1'b0, 1'b0, 1'b1, cls);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 3'd0);
  endtask

  initial begin
    rst = 1'b1; bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_class = 3'd0;
    model_update(1'b1, 1'b0, 1'b0, 3'd0);

    // Reset state, then fill with class 1
    do_reset();
    check("rst_valid", 32'(bus.decision_valid), 32'd0);
    check("rst_ones", 32'(bus.ones_count), 32'd0);
    for (int i = 0; i < 7; i++) sample(3'd1);
    check("fill7_valid", 32'(bus.decision_valid), 32'd0);
    check("fill7_ones", 32'(bus.ones_count), 32'd7);
    sample(3'd1);
    check("fill8_valid", 32'(bus.decision_valid), 32'd1);
    check("fill8_dec", 32'(bus.decision), 32'd1);
    check("fill8_chg", 32'(bus.decision_changed), 32'd0);
    check("fill8_samp", 32'(bus.sample_count), 32'd8);

    // Hysteresis hold then rising flip
    do_reset();
    for (int i = 0; i < 8; i++) sample(3'd0);
    for (int i = 0; i < 5; i++) sample(3'd1);
    check("hold_ones", 32'(bus.ones_count), 32'd5);
    check("hold_dec", 32'(bus.decision), 32'd0);
    sample(3'd1);
    check("rise_dec", 32'(bus.decision), 32'd1);
    check("rise_chg", 32'(bus.decision_changed), 32'd1);
    step(1'b0, 1'b0, 1'b0, 3'd0);
    check("rise_chg_off", 32'(bus.decision_changed), 32'd0);

    // Reach all-ones window, then flip back down
    sample(3'd1); sample(3'd1);
    check("full_ones", 32'(bus.ones_count), 32'd8);
    for (int i = 0; i < 5; i++) sample(3'd0);
    check("fall_hold_dec", 32'(bus.decision), 32'd1);
    sample(3'd0);
    check("fall_dec", 32'(bus.decision), 32'd0);
    check("fall_chg", 32'(bus.decision_changed), 32'd1);
    sample(3'd0);
    check("fall_chg_once", 32'(bus.decision_changed), 32'd0);

    // Tie at fill resolves to 0
    do_reset();
    for (int i = 0; i < 8; i++) sample(3'(i % 2));
    check("tie_valid", 32'(bus.decision_valid), 32'd1);
    check("tie_ones", 32'(bus.ones_count), 32'd4);
    check("tie_dec", 32'(bus.decision), 32'd0);

    // Illegal codes interleaved in a fill
    do_reset();
    sample(3'd1); sample(3'd5); sample(3'd1); sample(3'd1);
    sample(3'd7); sample(3'd1); sample(3'd1); sample(3'd1);
    check("ill_err", 32'(bus.err_count), 32'd2);
    check("ill_valid", 32'(bus.decision_valid), 32'd0);
    check("ill_samp", 32'(bus.sample_count), 32'd6);
    sample(3'd1);
    check("ill_valid7", 32'(bus.decision_valid), 32'd0);
    sample(3'd1);
    check("ill_valid8", 32'(bus.decision_valid), 32'd1);
    check("ill_ones", 32'(bus.ones_count), 32'd8);

    // Clear collides with a sample mid-TRACK
    sample(3'd0);
    step(1'b0, 1'b1, 1'b1, 3'd1);
    check("clr_valid", 32'(bus.decision_valid), 32'd0);
    check("clr_ones", 32'(bus.ones_count), 32'd0);
    check("clr_samp", 32'(bus.sample_count), 32'd0);
    for (int i = 0; i < 7; i++) sample(3'd1);
    check("clr_refill7", 32'(bus.decision_valid), 32'd0);
    sample(3'd1);
    check("clr_refill8", 32'(bus.decision_valid), 32'd1);

    // Counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) sample(3'(i % 2));
    check("sat_samp", 32'(bus.sample_count), 32'd15);
    for (int i = 0; i < 20; i++) sample(3'd6);
    check("sat_err", 32'(bus.err_count), 32'd15);
    check("sat_samp_hold", 32'(bus.sample_count), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/microgreen_vote_filter.md
# microgreen_vote_filter

Downstream stage of the microgreen BNN classifier. It consumes one classification result per inference (class code plus done strobe) and keeps a sliding window of the most recent results. It emits a debounced, hysteresis-filtered microgreen decision, and maintains sample and error counters for host readout. It removes single-inference flicker caused by noisy 4-bit sensor features before the result drives indicators or actuators.

## Interface
- WIN, 8, window depth in samples; legal range 2..16.
- THRESH, 6, votes required to flip the decision; legal range WIN/2 < THRESH <= WIN (integer division); elaboration error otherwise.
- CNT_W, 16, width of saturating counters.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- clear  in  1  synchronous soft clear; same effect as rst.
- in_valid  in  1  one classification result present this cycle; each high cycle is one sample, no backpressure.
- in_class  in  3  class code; 0 and 1 are legal, 2..7 are errors.
- decision  out  1  filtered class.
- decision_valid  out  1  high once the window has filled.
- decision_changed  out  1  one-cycle pulse when decision flips in TRACK.
- ones_count  out  clog2(WIN+1)  number of 1-votes in the current window.
- sample_count  out  CNT_W  legal samples accepted, saturating at all-ones.
- err_count  out  CNT_W  illegal class codes seen, saturating at all-ones.

## Operation
- State machine has two states: FILL (reset state) and TRACK.
- Window is a WIN-bit shift register. An accepted legal sample shifts in at bit 0; bit WIN-1 is the oldest vote.
- Accept rule: sample is legal when in_valid=1 and in_class<=1. Vote bit = in_class[0].
- Illegal sample: in_valid=1 and in_class>1. It increments err_count only. Window, ones_count, sample_count and state are untouched.
- ones_count update:
  - FILL: ones_count += vote.
  - TRACK: ones_count = ones_count + vote − oldest, where oldest is the bit shifted out.
  - ones_count never exceeds WIN.
- Fill counter counts legal samples in FILL. When the WIN-th legal sample is accepted:
  - state → TRACK.
  - decision_valid → 1.
  - decision = 1 if 2·ones_new > WIN, else 0 (a tie gives 0).
  - decision_changed stays 0.
- Hysteresis in TRACK, evaluated on the post-update ones_new for every accepted sample:
  - If decision=0 and ones_new >= THRESH: decision → 1, decision_changed pulses.
  - If decision=1 and (WIN − ones_new) >= THRESH: decision → 0, decision_changed pulses.
  - Otherwise decision holds.
- Arithmetic: all counts are unsigned. sample_count and err_count saturate and do not wrap. The increment and decrement of ones_count happen in the same cycle without overflow.
- rst or clear: state=FILL, window=0, ones_count=0, fill counter=0, decision=0, decision_valid=0, decision_changed=0, sample_count=0, err_count=0.
- clear together with in_valid: clear wins and the sample is dropped. rst has priority over clear.
- Reset mid-window discards the partial window; refill requires WIN fresh legal samples.

## Timing
- All outputs are registered and reflect a sample on the cycle after the edge where in_valid was sampled (1-cycle latency).
- decision_changed is high for exactly one cycle per flip and low in every cycle with no accepted sample.
- Back-to-back in_valid every cycle is supported at full rate. The upstream classifier strobes at most once per 5 cycles; the filter relies on neither rate.
- in_valid=0 cycles hold all state.
- The first decision_valid=1 appears 1 cycle after the WIN-th legal sample.

## Test plan
- Reset/fill: rst, then 7 samples of class 1 → decision_valid=0, ones_count=7. 8th sample → decision_valid=1, decision=1, decision_changed=0, sample_count=8.
- Hysteresis hold: fill with 8×class 0, then 5×class 1 → ones_count=5, decision stays 0. 6th class 1 → decision=1, decision_changed pulses one cycle.
- Flip back: from the all-1 window, feed 5×class 0 → decision 1 holds. 6th class 0 → decision=0 with a single pulse.
- Tie at fill: alternating 0,1 ×4 → decision_valid=1, ones_count=4, decision=0.
- Illegal codes: in_class=5 and 7 interleaved in a fill → err_count=2, sample_count and ones_count unchanged by them, and the fill still needs 8 legal samples.
- Clear collision: clear=1 with in_valid=1, class 1, mid-TRACK → next cycle all outputs 0 and state FILL. Saturation check with CNT_W=4: 20 legal samples → sample_count=15.
